// File: rtl/adc0832_pkg.sv
// Shared types and constants for the ADC0832 serial controller.
package adc0832_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_CLOCK = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int unsigned PULSES       = 12;
    localparam int unsigned CFG_PULSES   = 3;
    localparam int unsigned NULL_PULSE   = 4;
    localparam int unsigned GAP_HALVES   = 2;
    localparam logic        SGL_BIT      = 1'b1;
    localparam int unsigned CLOCK_HALVES = 2 * PULSES;
    localparam int unsigned HALF_W       = 5;
    localparam int unsigned DATA_W       = 8;

    localparam logic [1:0] SEL_IDLE = 2'b00;
    localparam logic [1:0] SEL_CH0  = 2'b01;
    localparam logic [1:0] SEL_CH1  = 2'b10;
    localparam logic [1:0] SEL_ALT  = 2'b11;

    // DI level presented during a given 1-based clock pulse: start, SGL, ODD/SIGN, then zero.
    function automatic logic di_for_pulse(input logic [HALF_W-1:0] pulse, input logic ch);
        logic bit_v;
        bit_v = 1'b0;
        if (pulse == HALF_W'(1))
            bit_v = 1'b1;
        else if (pulse == HALF_W'(2))
            bit_v = SGL_BIT;
        else if (pulse == HALF_W'(CFG_PULSES))
            bit_v = ch;
        return bit_v;
    endfunction

endpackage

// File: rtl/adc0832_tick.sv
// Half-period tick generator for the ADC serial clock.
module adc0832_tick #(
    parameter int unsigned HALF_DIV = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick_c
);

    localparam int unsigned CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick_c = (cnt == CNT_W'(HALF_DIV - 1));

    // Count system clocks; wrap on every tick, restart on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear || tick_c)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/adc0832_top.sv
// ADC0832 serial controller: drives CS/CLK/DI, shifts in results per channel.
module adc0832_top #(
    parameter int unsigned HALF_DIV = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sel,
    input  logic       D0832,
    output logic       DI,
    output logic       cs,
    output logic       finish,
    output logic       clk_0832,
    output logic [7:0] data_CH0,
    output logic [7:0] data_CH1
);

    import adc0832_pkg::*;

    state_t              state, state_nx;
    logic [HALF_W-1:0]   half_cnt, half_nx;
    logic [HALF_W-1:0]   pulse_c;
    logic                ch, ch_nx;
    logic                mode_alt, mode_nx;
    logic                alt_ch, alt_nx;
    logic [DATA_W-1:0]   shreg, shreg_nx;
    logic                cs_nx, sclk_nx, di_nx, finish_nx;
    logic [DATA_W-1:0]   d0_nx, d1_nx;
    logic                tick_c;
    logic                clear_c;

    // Tick counter restarts on every state entry and is held in IDLE.
    assign clear_c = (state_nx != state) || (state == ST_IDLE);

    // Pulse number whose DI/sample is being set up at the current tick.
    assign pulse_c = (half_cnt >> 1) + HALF_W'(2);

    adc0832_tick #(
        .HALF_DIV (HALF_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst),
        .clear  (clear_c),
        .tick_c (tick_c)
    );

    // State and all output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            half_cnt <= '0;
            ch       <= 1'b0;
            mode_alt <= 1'b0;
            alt_ch   <= 1'b0;
            shreg    <= '0;
            cs       <= 1'b1;
            clk_0832 <= 1'b0;
            DI       <= 1'b0;
            finish   <= 1'b0;
            data_CH0 <= '0;
            data_CH1 <= '0;
        end else begin
            state    <= state_nx;
            half_cnt <= half_nx;
            ch       <= ch_nx;
            mode_alt <= mode_nx;
            alt_ch   <= alt_nx;
            shreg    <= shreg_nx;
            cs       <= cs_nx;
            clk_0832 <= sclk_nx;
            DI       <= di_nx;
            finish   <= finish_nx;
            data_CH0 <= d0_nx;
            data_CH1 <= d1_nx;
        end
    end

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_nx  = state;
        half_nx   = half_cnt;
        ch_nx     = ch;
        mode_nx   = mode_alt;
        alt_nx    = alt_ch;
        shreg_nx  = shreg;
        cs_nx     = cs;
        sclk_nx   = clk_0832;
        di_nx     = DI;
        finish_nx = 1'b0;
        d0_nx     = data_CH0;
        d1_nx     = data_CH1;

        unique case (state)
            ST_IDLE: begin
                cs_nx   = 1'b1;
                sclk_nx = 1'b0;
                di_nx   = 1'b0;
                if (sel != SEL_IDLE) begin
                    state_nx = ST_SETUP;
                    half_nx  = '0;
                    mode_nx  = (sel == SEL_ALT);
                    if (sel == SEL_CH0)
                        ch_nx = 1'b0;
                    else if (sel == SEL_CH1)
                        ch_nx = 1'b1;
                    else
                        ch_nx = alt_ch;
                    cs_nx = 1'b0;
                    di_nx = 1'b1;
                end
            end

            ST_SETUP: begin
                if (tick_c) begin
                    state_nx = ST_CLOCK;
                    half_nx  = '0;
                    sclk_nx  = 1'b1;
                end
            end

            ST_CLOCK: begin
                if (tick_c) begin
                    if (!half_cnt[0]) begin
                        // End of high half: falling edge, present next DI bit.
                        sclk_nx = 1'b0;
                        di_nx   = di_for_pulse(pulse_c, ch);
                        half_nx = half_cnt + HALF_W'(1);
                    end else if (half_cnt == HALF_W'(CLOCK_HALVES - 1)) begin
                        // End of the last low half: release CS and publish result.
                        state_nx  = ST_GAP;
                        half_nx   = '0;
                        cs_nx     = 1'b1;
                        sclk_nx   = 1'b0;
                        di_nx     = 1'b0;
                        finish_nx = !mode_alt || ch;
                        alt_nx    = ~ch;
                        if (ch)
                            d1_nx = shreg;
                        else
                            d0_nx = shreg;
                    end else begin
                        // End of low half: rising edge, sample data past the null bit.
                        sclk_nx = 1'b1;
                        half_nx = half_cnt + HALF_W'(1);
                        if (pulse_c > HALF_W'(NULL_PULSE))
                            shreg_nx = {shreg[DATA_W-2:0], D0832};
                    end
                end
            end

            ST_GAP: begin
                cs_nx   = 1'b1;
                sclk_nx = 1'b0;
                if (tick_c) begin
                    if (half_cnt == HALF_W'(GAP_HALVES - 1)) begin
                        state_nx = ST_IDLE;
                        half_nx  = '0;
                    end else begin
                        half_nx = half_cnt + HALF_W'(1);
                    end
                end
            end

            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_adc0832_top.sv
// Randomized scoreboard bench for adc0832_top with a behavioural ADC0832 model.
module tb_adc0832_top;

    localparam int unsigned HALF_DIV = 4;
    localparam int FRAME = 27 * HALF_DIV + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sel = 2'b00;
    logic       D0832 = 1'b0;
    logic       DI, cs, finish, clk_0832;
    logic [7:0] data_CH0, data_CH1;

    adc0832_top #(.HALF_DIV(HALF_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .D0832    (D0832),
        .DI       (DI),
        .cs       (cs),
        .finish   (finish),
        .clk_0832 (clk_0832),
        .data_CH0 (data_CH0),
        .data_CH1 (data_CH1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural ADC0832 ----------------
    int         rise_cnt = 0;
    int         total_rises = 0;
    logic [15:0] di_rec = '0;
    logic [7:0] cur_val = 8'h00;
    bit         do_tie1 = 1'b0;

    always @(negedge cs) begin
        rise_cnt = 0;
        di_rec   = '0;
    end

    always @(posedge clk_0832) begin
        rise_cnt++;
        total_rises++;
        if (rise_cnt < 16) di_rec[rise_cnt[3:0]] = DI;
    end

    // DO: null bit after rise 3, then MSB-first data after rises 4..11.
    always @(negedge clk_0832) begin
        if (do_tie1)
            D0832 = 1'b1;
        else if (rise_cnt >= 4 && rise_cnt <= 11)
            D0832 = cur_val[11 - rise_cnt];
        else
            D0832 = 1'b0;
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        bit         ch;
        logic [7:0] val;
        bit         fin;
    } exp_t;

    exp_t q[$];
    bit   cs_q = 1'b1;
    bit   alt_next = 1'b0;
    logic [7:0] exp_d0 = 8'h00, exp_d1 = 8'h00;
    int   cyc = 0, fin_cnt = 0, last_fin = 0, cs_low_cycles = 0;
    bit   last_fin_ok = 1'b0, period_chk = 1'b0;
    int   force_val = -1;

    initial begin : monitor
        exp_t e;
        logic [15:0] dexp;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst) begin
                q.delete();
                alt_next = 1'b0;
                exp_d0 = 8'h00;
                exp_d1 = 8'h00;
                cs_q = 1'b1;
                continue;
            end
            if (cs_q && !cs) begin
                // Frame start: channel from the sel rules and the alternation history.
                e.ch  = (sel == 2'b01) ? 1'b0 : (sel == 2'b10) ? 1'b1 : alt_next;
                e.fin = (sel != 2'b11) || e.ch;
                alt_next = !e.ch;
                if (do_tie1)
                    e.val = 8'hFF;
                else if (force_val >= 0)
                    e.val = 8'(force_val);
                else
                    e.val = 8'($urandom);
                cur_val = e.val;
                q.push_back(e);
            end else if (!cs_q && cs) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_end: got unexpected frame end expected none at %0t", $time);
                end else begin
                    e = q.pop_front();
                    if (e.ch) exp_d1 = e.val; else exp_d0 = e.val;
                    dexp = '0;
                    dexp[1] = 1'b1;
                    dexp[2] = 1'b1;
                    dexp[3] = e.ch;
                    chk("data_CH0", 16'(data_CH0), 16'(exp_d0));
                    chk("data_CH1", 16'(data_CH1), 16'(exp_d1));
                    chk("finish_at_end", 16'(finish), 16'(e.fin));
                    chk("rises_per_frame", 16'(rise_cnt), 16'd12);
                    chk("di_bits", di_rec, dexp);
                end
            end else if (finish) begin
                errors++;
                $display("FAIL finish_stray: got 1 expected 0 at %0t", $time);
            end
            if (finish) begin
                fin_cnt++;
                if (period_chk && last_fin_ok)
                    chk("finish_period", 16'(cyc - last_fin), 16'(FRAME));
                last_fin = cyc;
                last_fin_ok = 1'b1;
            end
            if (!period_chk) last_fin_ok = 1'b0;
            if (!cs) cs_low_cycles++;
            cs_q = cs;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_fin(input int n, input int budget);
        int target;
        int k;
        target = fin_cnt + n;
        k = 0;
        while (fin_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (fin_cnt < target) begin
            errors++;
            $display("FAIL finish_timeout: got %0d expected %0d", fin_cnt, target);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic drain();
        sel = 2'b00;
        repeat (FRAME + 10) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cs"}, 16'(cs), 16'd1);
        chk({tag, "_clk0832"}, 16'(clk_0832), 16'd0);
        chk({tag, "_di"}, 16'(DI), 16'd0);
        chk({tag, "_finish"}, 16'(finish), 16'd0);
        chk({tag, "_d0"}, 16'(data_CH0), 16'd0);
        chk({tag, "_d1"}, 16'(data_CH1), 16'd0);
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk_reset_vals("rst_hold");

        // Idle selection: nothing moves for 1000 clocks.
        rst = 1'b1;
        repeat (1000) @(negedge clk);
        chk("idle_cs_low", 16'(cs_low_cycles), 16'd0);
        chk("idle_rises", 16'(total_rises), 16'd0);
        chk("idle_finish", 16'(fin_cnt), 16'd0);

        // Alternating round with DO tied high.
        do_tie1 = 1'b1;
        sel = 2'b11;
        wait_fin(1, 3 * FRAME);
        drain();
        chk("alt_rises", 16'(total_rises), 16'd24);
        chk("alt_d0", 16'(data_CH0), 16'hFF);
        chk("alt_d1", 16'(data_CH1), 16'hFF);
        do_tie1 = 1'b0;

        // CH0 only, value A5, back-to-back frames.
        pulse_reset();
        force_val = 8'hA5;
        period_chk = 1'b1;
        sel = 2'b01;
        wait_fin(3, 4 * FRAME);
        period_chk = 1'b0;
        drain();
        chk("ch0_d0", 16'(data_CH0), 16'hA5);
        chk("ch0_d1", 16'(data_CH1), 16'h00);

        // CH1 only, value 3C.
        force_val = 8'h3C;
        sel = 2'b10;
        wait_fin(1, 2 * FRAME);
        drain();
        chk("ch1_d0", 16'(data_CH0), 16'hA5);
        chk("ch1_d1", 16'(data_CH1), 16'h3C);

        // sel 11 -> 01 during the CH0 frame.
        pulse_reset();
        force_val = -1;
        sel = 2'b11;
        begin
            int k;
            k = 0;
            while (cs && k < 20) begin
                @(negedge clk);
                k++;
            end
        end
        repeat (20) @(negedge clk);
        sel = 2'b01;
        wait_fin(2, 4 * FRAME);
        drain();
        chk("switch_d1", 16'(data_CH1), 16'h00);

        // Randomized selection changes and data values.
        for (int i = 0; i < 10; i++) begin
            sel = 2'($urandom_range(1, 3));
            repeat ($urandom_range(30, 260)) @(negedge clk);
        end
        drain();
        chk("random_queue_empty", 16'(q.size()), 16'd0);

        // Asynchronous reset in the middle of CLOCK.
        sel = 2'b01;
        begin
            int k;
            k = 0;
            while (!clk_0832 && k < 2 * FRAME) begin
                @(negedge clk);
                k++;
            end
            if (!clk_0832) begin
                errors++;
                $display("FAIL midframe_wait: got clk_0832 0 expected 1");
            end
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_reset_vals("rst_async");
        sel = 2'b00;
        @(negedge clk) rst = 1'b1;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
